// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: turns one rectangle command into a row-major stream of
// frame-buffer pixel writes, with off-screen clipping and downstream back-pressure.
module rect_fill_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int COLOUR_W = 9
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W-1:0]      width,
  input  logic [Y_W-1:0]      height,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                plot_ready,
  output logic                busy,
  output logic                done,
  output logic [X_W-1:0]      plot_x,
  output logic [Y_W-1:0]      plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                plot
);

  typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

  state_t               state_reg, state_next;
  logic [X_W-1:0]       x0_reg, x0_next;
  logic [Y_W-1:0]       y0_reg, y0_next;
  logic [X_W-1:0]       w_reg, w_next;
  logic [Y_W-1:0]       h_reg, h_next;
  logic [COLOUR_W-1:0]  colour_reg, colour_next;
  logic [X_W-1:0]       cx_reg, cx_next;
  logic [Y_W-1:0]       cy_reg, cy_next;
  logic                 busy_reg, busy_next;
  logic                 done_reg, done_next;
  logic                 plot_reg, plot_next;
  logic [X_W-1:0]       plot_x_reg, plot_x_next;
  logic [Y_W-1:0]       plot_y_reg, plot_y_next;
  logic [COLOUR_W-1:0]  plot_colour_reg, plot_colour_next;

  logic                 pix_update;
  logic                 last_col, last_row;
  logic [X_W-1:0]       base_x;
  logic [Y_W-1:0]       base_y;
  logic [COLOUR_W-1:0]  base_colour;
  logic [X_W:0]         sum_x;
  logic [Y_W:0]         sum_y;

  assign last_col = (cx_reg == w_reg - X_W'(1));
  assign last_row = (cy_reg == h_reg - Y_W'(1));

  // The first pixel is formed straight from the command inputs during acceptance.
  assign base_x      = (state_reg == IDLE) ? x0     : x0_reg;
  assign base_y      = (state_reg == IDLE) ? y0     : y0_reg;
  assign base_colour = (state_reg == IDLE) ? colour : colour_reg;

  always_comb begin
    state_next       = state_reg;
    x0_next          = x0_reg;
    y0_next          = y0_reg;
    w_next           = w_reg;
    h_next           = h_reg;
    colour_next      = colour_reg;
    cx_next          = cx_reg;
    cy_next          = cy_reg;
    busy_next        = busy_reg;
    done_next        = 1'b0;
    plot_next        = plot_reg;
    plot_x_next      = plot_x_reg;
    plot_y_next      = plot_y_reg;
    plot_colour_next = plot_colour_reg;
    pix_update       = 1'b0;
    sum_x            = '0;
    sum_y            = '0;

    case (state_reg)
      IDLE: begin
        busy_next = 1'b0;
        plot_next = 1'b0;
        if (start) begin
          x0_next     = x0;
          y0_next     = y0;
          w_next      = width;
          h_next      = height;
          colour_next = colour;
          cx_next     = '0;
          cy_next     = '0;
          if (width == '0 || height == '0) begin
            state_next = FIN;
            done_next  = 1'b1;
          end else begin
            state_next = DRAW;
            busy_next  = 1'b1;
            pix_update = 1'b1;
          end
        end
      end
      DRAW: begin
        // A clipped pixel (plot low) never waits for the downstream port.
        if (!plot_reg || plot_ready) begin
          if (last_col && last_row) begin
            state_next = FIN;
            busy_next  = 1'b0;
            plot_next  = 1'b0;
            done_next  = 1'b1;
          end else if (last_col) begin
            cx_next    = '0;
            cy_next    = cy_reg + Y_W'(1);
            pix_update = 1'b1;
          end else begin
            cx_next    = cx_reg + X_W'(1);
            pix_update = 1'b1;
          end
        end
      end
      FIN: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        plot_next  = 1'b0;
      end
      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        plot_next  = 1'b0;
      end
    endcase

    if (pix_update) begin
      sum_x            = {1'b0, base_x} + {1'b0, cx_next};
      sum_y            = {1'b0, base_y} + {1'b0, cy_next};
      plot_x_next      = sum_x[X_W-1:0];
      plot_y_next      = sum_y[Y_W-1:0];
      plot_colour_next = base_colour;
      plot_next        = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg       <= IDLE;
      x0_reg          <= '0;
      y0_reg          <= '0;
      w_reg           <= '0;
      h_reg           <= '0;
      colour_reg      <= '0;
      cx_reg          <= '0;
      cy_reg          <= '0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      plot_reg        <= 1'b0;
      plot_x_reg      <= '0;
      plot_y_reg      <= '0;
      plot_colour_reg <= '0;
    end else begin
      state_reg       <= state_next;
      x0_reg          <= x0_next;
      y0_reg          <= y0_next;
      w_reg           <= w_next;
      h_reg           <= h_next;
      colour_reg      <= colour_next;
      cx_reg          <= cx_next;
      cy_reg          <= cy_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      plot_reg        <= plot_next;
      plot_x_reg      <= plot_x_next;
      plot_y_reg      <= plot_y_next;
      plot_colour_reg <= plot_colour_next;
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign plot        = plot_reg;
  assign plot_x      = plot_x_reg;
  assign plot_y      = plot_y_reg;
  assign plot_colour = plot_colour_reg;

endmodule

// File: tb/tb_rect_fill_engine.sv
// Bench for rect_fill_engine: a queue-based pixel model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_rect_fill_engine;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int SW  = 160;
  localparam int SH  = 120;
  localparam int CW  = 9;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [X_W-1:0] x0 = '0, width = '0;
  logic [Y_W-1:0] y0 = '0, height = '0;
  logic [CW-1:0]  colour = '0;
  logic          plot_ready = 1'b1;
  logic          busy, done, plot;
  logic [X_W-1:0] plot_x;
  logic [Y_W-1:0] plot_y;
  logic [CW-1:0]  plot_colour;

  rect_fill_engine #(.X_W(X_W), .Y_W(Y_W), .SCREEN_W(SW), .SCREEN_H(SH), .COLOUR_W(CW)) dut (
    .clock(clock), .resetn(resetn), .start(start), .x0(x0), .y0(y0),
    .width(width), .height(height), .colour(colour), .plot_ready(plot_ready),
    .busy(busy), .done(done), .plot_x(plot_x), .plot_y(plot_y),
    .plot_colour(plot_colour), .plot(plot)
  );

  always #5 clock = ~clock;

  typedef struct { logic [X_W-1:0] x; logic [Y_W-1:0] y; bit on; } pix_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs for the current cycle plus the pixels still to come.
  pix_t          pq[$];
  bit            m_busy = 0, m_done = 0, m_plot = 0, m_xy_known = 1;
  logic [X_W-1:0] m_x = '0;
  logic [Y_W-1:0] m_y = '0;
  logic [CW-1:0]  m_col = '0;

  int busy_cycles = 0, write_count = 0, done_count = 0;
  logic [X_W-1:0] wr_x[$];
  logic [Y_W-1:0] wr_y[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  task automatic load_next();
    pix_t p;
    p = pq.pop_front();
    m_x = p.x;
    m_y = p.y;
    m_plot = p.on;
  endtask

  // Next-cycle expectation from this cycle's inputs.
  task automatic predict();
    if (!resetn) begin
      pq.delete();
      m_busy = 0; m_done = 0; m_plot = 0; m_xy_known = 1;
      m_x = '0; m_y = '0; m_col = '0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_busy) begin
      if (!m_plot || plot_ready) begin
        if (pq.size() == 0) begin
          m_busy = 0; m_plot = 0; m_done = 1; m_xy_known = 0;
        end else begin
          load_next();
        end
      end
    end else if (start) begin
      for (int r = 0; r < int'(height); r++) begin
        for (int c = 0; c < int'(width); c++) begin
          pix_t p;
          int sx, sy;
          sx = int'(x0) + c;
          sy = int'(y0) + r;
          p.x = sx[X_W-1:0];
          p.y = sy[Y_W-1:0];
          p.on = (sx < SW) && (sy < SH);
          pq.push_back(p);
        end
      end
      if (pq.size() == 0) begin
        m_done = 1;
      end else begin
        m_col = colour;
        m_busy = 1;
        m_xy_known = 1;
        load_next();
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    forever begin
      @(negedge clock);
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("plot", 32'(plot), 32'(m_plot));
      if (m_xy_known) begin
        chk("plot_x", 32'(plot_x), 32'(m_x));
        chk("plot_y", 32'(plot_y), 32'(m_y));
        chk("plot_colour", 32'(plot_colour), 32'(m_col));
      end
      if (busy) busy_cycles++;
      if (plot && plot_ready) begin
        write_count++;
        wr_x.push_back(plot_x);
        wr_y.push_back(plot_y);
      end
      if (done) begin
        done_count++;
        $display("txn done at %0t: total writes %0d", $time, write_count);
      end
      predict();
    end
  end

  task automatic issue(input int x, input int y, input int w, input int h, input int c);
    start = 1'b1;
    x0 = X_W'(x); y0 = Y_W'(y); width = X_W'(w); height = Y_W'(h); colour = CW'(c);
    @(posedge clock); #1;
    start = 1'b0;
    x0 = X_W'($urandom); y0 = Y_W'($urandom); width = X_W'($urandom);
    height = Y_W'($urandom); colour = CW'($urandom);
  endtask

  task automatic wait_done(input int d0, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clock); #1;
      if (done_count > d0) break;
    end
    if (i == budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got no done within %0d cycles want done", budget);
    end
  endtask

  task automatic chk_write(input string name, input int idx, input int ex, input int ey);
    if (idx < wr_x.size()) begin
      chk(name, 32'({wr_x[idx], 8'h00, 1'b0, wr_y[idx]}), 32'({X_W'(ex), 8'h00, 1'b0, Y_W'(ey)}));
    end else begin
      chk(name, 32'(wr_x.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    int b0, w0, d0;
    repeat (3) @(posedge clock); #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_plot", 32'(plot), 32'd0);
    chk("rst_plot_x", 32'(plot_x), 32'd0);
    chk("rst_plot_y", 32'(plot_y), 32'd0);
    chk("rst_plot_colour", 32'(plot_colour), 32'd0);
    resetn = 1'b1;
    @(posedge clock); #1;

    // Basic 2x2 fill
    b0 = busy_cycles; w0 = wr_x.size(); d0 = done_count;
    issue(10, 20, 2, 2, 'h1C0);
    wait_done(d0, 50);
    chk("basic_busy_cycles", 32'(busy_cycles - b0), 32'd4);
    chk("basic_writes", 32'(wr_x.size() - w0), 32'd4);
    chk_write("basic_px0", w0,     10, 20);
    chk_write("basic_px1", w0 + 1, 11, 20);
    chk_write("basic_px2", w0 + 2, 10, 21);
    chk_write("basic_px3", w0 + 3, 11, 21);

    // Empty commands
    b0 = busy_cycles; w0 = wr_x.size(); d0 = done_count;
    issue(3, 3, 0, 5, 'h1FF);
    wait_done(d0, 10);
    issue(3, 3, 3, 0, 'h1FF);
    wait_done(d0 + 1, 10);
    chk("empty_busy_cycles", 32'(busy_cycles - b0), 32'd0);
    chk("empty_writes", 32'(wr_x.size() - w0), 32'd0);
    chk("empty_dones", 32'(done_count - d0), 32'd2);

    // Clipping at the bottom-right corner
    b0 = busy_cycles; w0 = wr_x.size(); d0 = done_count;
    issue(158, 119, 4, 2, 'h0AA);
    wait_done(d0, 50);
    chk("clip_busy_cycles", 32'(busy_cycles - b0), 32'd8);
    chk("clip_writes", 32'(wr_x.size() - w0), 32'd2);
    chk_write("clip_px0", w0,     158, 119);
    chk_write("clip_px1", w0 + 1, 159, 119);

    // Back-pressure on the second pixel
    b0 = busy_cycles; w0 = wr_x.size(); d0 = done_count;
    issue(0, 0, 3, 1, 'h055);
    @(posedge clock); #1;
    plot_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1 plot_ready = 1'b1;
    wait_done(d0, 50);
    chk("bp_busy_cycles", 32'(busy_cycles - b0), 32'd6);
    chk("bp_writes", 32'(wr_x.size() - w0), 32'd3);
    chk_write("bp_px0", w0,     0, 0);
    chk_write("bp_px1", w0 + 1, 1, 0);
    chk_write("bp_px2", w0 + 2, 2, 0);

    // Start while busy is ignored
    w0 = wr_x.size(); d0 = done_count;
    issue(30, 30, 4, 4, 'h123);
    repeat (4) @(posedge clock);
    #1;
    start = 1'b1; x0 = 8'd50; y0 = 7'd60; width = 8'd2; height = 7'd2; colour = 9'h0F0;
    @(posedge clock); #1 start = 1'b0;
    wait_done(d0, 80);
    repeat (6) @(posedge clock); #1;
    chk("sb_writes", 32'(wr_x.size() - w0), 32'd16);
    chk("sb_dones", 32'(done_count - d0), 32'd1);
    chk_write("sb_last_px", w0 + 15, 33, 33);

    // Reset in the third DRAW cycle
    d0 = done_count;
    issue(40, 40, 4, 4, 'h1AB);
    @(posedge clock); #1;
    @(posedge clock); #1;
    resetn = 1'b0;
    @(posedge clock); #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_plot", 32'(plot), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_xy", 32'({plot_x, plot_y, plot_colour}), 32'd0);
    resetn = 1'b1;
    repeat (6) @(posedge clock); #1;
    chk("mid_rst_no_done", 32'(done_count - d0), 32'd0);
    w0 = wr_x.size();
    issue(5, 5, 1, 1, 'h111);
    wait_done(d0, 20);
    chk("post_rst_writes", 32'(wr_x.size() - w0), 32'd1);
    chk_write("post_rst_px", w0, 5, 5);

    // Randomized traffic; the per-cycle model carries the checking
    for (int i = 0; i < 4000; i++) begin
      plot_ready = ($urandom_range(0, 3) != 0);
      start = ($urandom_range(0, 7) == 0);
      x0 = ($urandom_range(0, 1) != 0) ? X_W'($urandom_range(150, 255)) : X_W'($urandom_range(0, 159));
      y0 = ($urandom_range(0, 1) != 0) ? Y_W'($urandom_range(112, 127)) : Y_W'($urandom_range(0, 119));
      width = X_W'($urandom_range(0, 6));
      height = Y_W'($urandom_range(0, 5));
      colour = CW'($urandom);
      resetn = ($urandom_range(0, 599) != 0);
      @(posedge clock); #1;
    end
    start = 1'b0; plot_ready = 1'b1; resetn = 1'b1;
    repeat (60) @(posedge clock); #1;
    chk("final_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
